// File: rtl/cpu_pkg.sv
// Shared CPU package: opcode/funct constants,
// instruction field positions and the fetch state type.
package cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 26;
  localparam int RS_HI  = 25;
  localparam int RS_LO  = 21;
  localparam int RT_HI  = 20;
  localparam int RT_LO  = 16;
  localparam int RD_HI  = 15;
  localparam int RD_LO  = 11;
  localparam int FN_HI  = 5;
  localparam int FN_LO  = 0;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;

  typedef enum logic {
    S_FETCH = 1'b0,
    S_HOLD  = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load captures a fetched word,
// flush clears only the valid bit, otherwise contents hold.
module if_id_reg #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              flush,
  input  logic [31:0]       instr_in,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              valid,
  output logic [31:0]       ir,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid    <= 1'b0;
      ir       <= '0;
      pc       <= '0;
      pc_plus4 <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid    <= 1'b1;
      ir       <= instr_in;
      pc       <= pc_in;
      pc_plus4 <= pc_in + ADDR_W'(4);
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, imem handshake, IF/ID register.
// Optional FETCH_PERF_CNT_EN adds fetch/stall perf counters.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              if_valid,
  output logic [ADDR_W-1:0] if_pc,
  output logic [ADDR_W-1:0] if_pc_plus4,
  output logic [5:0]        opcode,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [5:0]        funct,
  output logic [15:0]       imm
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_stall_cnt
`endif
);

  localparam logic [ADDR_W-1:0] ALIGN = ~ADDR_W'(3);
  localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(4);

  fetch_state_t      state, state_nx;
  logic [ADDR_W-1:0] pc, pc_nx;
  logic              load, flush;
  logic [31:0]       ir;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
      pc    <= RESET_PC;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
    end
  end

  // redirect wins over ack and stall
  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    load     = 1'b0;
    flush    = 1'b0;
    unique case (1'b1)
      redirect: begin
        pc_nx    = redirect_pc & ALIGN;
        flush    = 1'b1;
        state_nx = S_FETCH;
      end
      (!redirect && state == S_FETCH): begin
        if (imem_ack) begin
          load     = 1'b1;
          pc_nx    = pc + STEP;
          state_nx = S_HOLD;
        end
      end
      (!redirect && state == S_HOLD): begin
        if (!stall) begin
          flush    = 1'b1;
          state_nx = S_FETCH;
        end
      end
      default: ;
    endcase
  end

  assign imem_req  = !rst && (state == S_FETCH);
  assign imem_addr = pc;

  if_id_reg #(
    .ADDR_W(ADDR_W)
  ) u_if_id (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .flush   (flush),
    .instr_in(imem_rdata),
    .pc_in   (pc),
    .valid   (if_valid),
    .ir      (ir),
    .pc      (if_pc),
    .pc_plus4(if_pc_plus4)
  );

  assign opcode = ir[OPC_HI:OPC_LO];
  assign rs     = ir[RS_HI:RS_LO];
  assign rt     = ir[RT_HI:RT_LO];
  assign rd     = ir[RD_HI:RD_LO];
  assign funct  = ir[FN_HI:FN_LO];
  assign imm    = ir[IMM_HI:IMM_LO];

`ifdef FETCH_PERF_CNT_EN
  logic stall_ev;
  assign stall_ev = (state == S_HOLD && stall)
                  || (imem_req && !imem_ack);

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (load && perf_fetch_cnt != '1)
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (stall_ev && perf_stall_cnt != '1)
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the control unit.
- Holds the PC and drives a request/acknowledge instruction-memory interface.
- Latches the returned word into an IF/ID register and presents decoded fields (opcode, funct, rs, rt, rd, imm) with a valid flag to the control unit and datapath.
- Supports a downstream stall and a branch redirect that flushes the in-flight fetch.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- ADDR_W, 32, PC and memory address width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- imem_req  out  1  fetch request, level
- imem_addr  out  ADDR_W  word-aligned fetch address (current PC)
- imem_ack  in  1  rdata valid for the address presented this cycle; ignored when imem_req=0
- imem_rdata  in  32  instruction word
- stall  in  1  downstream cannot accept; hold the IF/ID contents
- redirect  in  1  branch taken; load a new PC
- redirect_pc  in  ADDR_W  branch target; bits [1:0] ignored (forced 00)
- if_valid  out  1  IF/ID holds a valid instruction
- if_pc  out  ADDR_W  PC of the held instruction
- if_pc_plus4  out  ADDR_W  if_pc+4
- opcode  out  6  instr[31:26]
- rs  out  5  instr[25:21]
- rt  out  5  instr[20:16]
- rd  out  5  instr[15:11]
- funct  out  6  instr[5:0]
- imm  out  16  instr[15:0]

Behaviour:
- States: S_FETCH (imem_req=1, imem_addr=pc) and S_HOLD (if_valid=1, imem_req=0).
- Reset (rst=1 at a clock edge):
  - pc=RESET_PC, state=S_FETCH, if_valid=0, IR=0, so all fields are 0; if_pc=0, if_pc_plus4=0.
  - imem_req is forced to 0 while rst=1.
  - The first request is issued in the first cycle after rst deasserts.
- Reset mid-fetch: any pending ack is discarded and the same reset values apply.
- S_FETCH:
  - imem_ack=1 and redirect=0: IR<=imem_rdata, if_pc<=pc, if_pc_plus4<=pc+4, pc<=pc+4, if_valid<=1, go S_HOLD.
  - imem_ack=0: stay; pc and address stay stable.
- S_HOLD:
  - stall=1: all IF/ID outputs hold.
  - stall=0: if_valid<=0, go S_FETCH.
  - Minimum issue interval is 2 cycles with zero-wait memory.
- Redirect (highest priority, any state, overrides stall and ack):
  - pc<={redirect_pc[31:2],2'b00}, if_valid<=0, go S_FETCH.
  - An ack in the same cycle is discarded and IR is not updated.
  - A request is issued to the new address on the next cycle.
- Arithmetic: pc+4 is modulo 2^ADDR_W; 32'hFFFF_FFFC wraps to 0 with no flag.
- Memory contract: the requester may change imem_addr or drop imem_req in any cycle; no outstanding transactions exist beyond the current cycle.
- The decoded fields are pure slices of IR, with no further decode logic.
- Outputs when if_valid=0: fields retain the last IR value; consumers must qualify with if_valid.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_fetch_cnt[31:0] and perf_stall_cnt[31:0], both reset to 0.
  - perf_fetch_cnt increments on each accepted ack that is not discarded.
  - perf_stall_cnt increments on each cycle in S_HOLD with stall=1, or in S_FETCH with imem_req=1 and imem_ack=0.
  - Both saturate at 32'hFFFF_FFFF.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package cpu_pkg:
  - Opcode constants: OP_RTYPE 6'b000000, OP_LW 6'b100011, OP_SW 6'b101011, OP_BEQ 6'b000100.
  - Funct constants: ADD 100000, SUB 100010, AND 100100, OR 100101.
  - Instruction field bit-position constants.
  - Fetch state enum.
- Sub-module if_id_reg: IR/if_pc/if_pc_plus4/if_valid register with load, hold and flush controls.
- The FSM and PC stay in fetch_stage.

Test Plan:
- Reset: hold rst 2 cycles, release → imem_req=0 during reset, 1 on the first cycle after, imem_addr=0, if_valid=0, opcode=0.
- Sequential fetch, zero-wait memory: words 0x8C220004 (lw), 0x00430820 (add) at 0x0/0x4 → if_valid pulses with opcode=100011, rt=2, imm=0x0004, then opcode=0, funct=100000, rd=1, if_pc=0x4, if_pc_plus4=0x8.
- Memory latency 3 cycles, then stall=1 for 4 cycles → imem_addr stable during the wait; IF/ID fields unchanged while stalled; next request goes to pc+4 after stall drops.
- redirect=1, redirect_pc=0x0000_0103, in the same cycle as imem_ack=1 → IR unchanged, if_valid=0, next imem_addr=0x0000_0100.
- RESET_PC=0xFFFF_FFFC, fetch one word → if_pc_plus4=0 and the next imem_addr=0; rst asserted mid-wait → pc returns to RESET_PC and the ack is ignored.
- With FETCH_PERF_CNT_EN: 5 fetches with 2 stall cycles each → perf_fetch_cnt=5, perf_stall_cnt=10.
